// File: rtl/sram_like_responder.sv
// SRAM-like responder: word memory behind req/addr_ok/data_ok, in-order responses after >= LATENCY cycles.
// Up to DEPTH requests outstanding; addr_ok drops when full unless the head response leaves this cycle.
module sram_like_responder #(
    parameter int ADDR_W  = 10,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [3:0]  wstrb,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int TW = $clog2(LATENCY + 1);

    logic [31:0]       mem   [2**ADDR_W];
    logic              q_rd  [DEPTH];
    logic [31:0]       q_dat [DEPTH];
    logic [TW-1:0]     q_cnt [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] idx;
    logic              pop;
    logic              accept;

    // size is informational and the address wraps, so these bits are intentionally ignored
    logic unused_bits;
    assign unused_bits = ^{size, addr[31:ADDR_W+2], addr[1:0]};

    assign idx     = addr[ADDR_W+1:2];
    assign pop     = (count != '0) && (q_cnt[rd_ptr] == '0);
    assign addr_ok = !reset && ((count < CW'(DEPTH)) || pop);
    assign accept  = req && addr_ok;
    assign data_ok = pop;
    assign rdata   = (pop && q_rd[rd_ptr]) ? q_dat[rd_ptr] : 32'h0;

    always_ff @(posedge clk) begin
        if (accept && wr) begin
            for (int b = 0; b < 4; b++) begin
                if (wstrb[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_cnt[i] <= '0;
                q_rd[i]  <= 1'b0;
                q_dat[i] <= 32'h0;
            end
        end else begin
            // every entry counts down, so queued requests mature back to back
            for (int i = 0; i < DEPTH; i++) begin
                if (q_cnt[i] != '0) q_cnt[i] <= q_cnt[i] - 1'b1;
            end
            if (accept) begin
                q_cnt[wr_ptr] <= TW'(LATENCY - 1);
                q_rd[wr_ptr]  <= !wr;
                q_dat[wr_ptr] <= wr ? 32'h0 : mem[idx];
                wr_ptr        <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
